// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding and
// derivation of the bit-period timing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_t;

  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Counter must hold 0..CLKS_PER_BIT-1; never narrower than one bit.
  function automatic int calc_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clocks within one serial bit and flags the last one.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Wraps on its own at the end of every bit so consecutive bits need no extra clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Single-frame UART transmitter: start bit, 8 data bits LSB-first, optional
// parity, 1 or 2 stop bits. All outputs are registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ    = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int PARITY_ENABLE = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       uart_busy,
  output logic       tx_serial,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W        = calc_cnt_w(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_t state, state_n;
  logic [7:0]  shift_q, shift_n;
  logic [7:0]  data_q, data_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        stop_idx, stop_idx_n;
  logic        serial_n, busy_n, done_n;
  logic        bit_end;
  logic        parity_bit;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == UART_IDLE),
    .bit_end(bit_end)
  );

  // Parity comes from the byte latched at accept, since the shifter is consumed.
  assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= UART_IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      tx_serial <= 1'b1;
      uart_busy <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_q   <= shift_n;
      data_q    <= data_n;
      bit_idx   <= bit_idx_n;
      stop_idx  <= stop_idx_n;
      tx_serial <= serial_n;
      uart_busy <= busy_n;
      tx_done   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift_q;
    data_n     = data_q;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;

    case (state)
      UART_IDLE: begin
        if (tx_start) begin
          state_n    = UART_START;
          shift_n    = tx_data;
          data_n     = tx_data;
          bit_idx_n  = 3'd0;
          stop_idx_n = 1'b0;
        end
      end
      UART_START: begin
        if (bit_end) state_n = UART_DATA;
      end
      UART_DATA: begin
        if (bit_end) begin
          shift_n   = {1'b0, shift_q[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = (PARITY_ENABLE != 0) ? UART_PARITY : UART_STOP;
          end
        end
      end
      UART_PARITY: begin
        if (bit_end) state_n = UART_STOP;
      end
      UART_STOP: begin
        if (bit_end) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_n = UART_IDLE;
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: state_n = UART_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    case (state_n)
      UART_START:  serial_n = 1'b0;
      UART_DATA:   serial_n = shift_n[0];
      UART_PARITY: serial_n = parity_bit;
      default:     serial_n = 1'b1;
    endcase

    busy_n = (state_n != UART_IDLE);
    done_n = (state == UART_STOP) && (state_n == UART_IDLE);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: four transmitter configurations at 16 clocks per bit,
// directed and random frames compared against a bit-list reference model.
module tb_uart_transmitter;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] start;
  logic [7:0] data;
  wire  [3:0] busy;
  wire  [3:0] ser;
  wire  [3:0] done;

  int errors = 0;
  int checks = 0;
  logic [255:0] last_obs;

  uart_transmitter #(.CLOCK_FREQ(16), .BAUD_RATE(1), .PARITY_ENABLE(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.clock(clk), .reset(rst_n), .tx_start(start[0]), .tx_data(data),
            .uart_busy(busy[0]), .tx_serial(ser[0]), .tx_done(done[0]));
  uart_transmitter #(.CLOCK_FREQ(16), .BAUD_RATE(1), .PARITY_ENABLE(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut1 (.clock(clk), .reset(rst_n), .tx_start(start[1]), .tx_data(data),
            .uart_busy(busy[1]), .tx_serial(ser[1]), .tx_done(done[1]));
  uart_transmitter #(.CLOCK_FREQ(16), .BAUD_RATE(1), .PARITY_ENABLE(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_dut2 (.clock(clk), .reset(rst_n), .tx_start(start[2]), .tx_data(data),
            .uart_busy(busy[2]), .tx_serial(ser[2]), .tx_done(done[2]));
  uart_transmitter #(.CLOCK_FREQ(16), .BAUD_RATE(1), .PARITY_ENABLE(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_dut3 (.clock(clk), .reset(rst_n), .tx_start(start[3]), .tx_data(data),
            .uart_busy(busy[3]), .tx_serial(ser[3]), .tx_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_en(input int idx);
    return (idx == 1 || idx == 2) ? 1 : 0;
  endfunction

  function automatic int par_odd(input int idx);
    return (idx == 2) ? 1 : 0;
  endfunction

  function automatic int stop_bits(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len_bits(input int idx);
    return 10 + par_en(idx) + stop_bits(idx) - 1;
  endfunction

  // Line levels in transmit order, one entry per bit period; unused tail is idle-high.
  function automatic logic [15:0] frame_bits(input int idx, input logic [7:0] b);
    logic [15:0] bits;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    if (par_en(idx) != 0) bits[9] = (($countones(b) % 2) == 1) ^ (par_odd(idx) != 0);
    return bits;
  endfunction

  task automatic check(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_vec(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    @(negedge clk);
    data       = b;
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    data       = 8'($urandom);
  endtask

  // Entered just after the accept edge; ends at the sample of the idle cycle after the frame.
  task automatic check_frame(input int idx, input logic [7:0] b, input int inject_at);
    logic [15:0]  fb;
    logic [255:0] obs;
    logic [255:0] exp;
    int nb;
    int len;
    int busy_cnt;
    int done_cnt;
    fb       = frame_bits(idx, b);
    nb       = frame_len_bits(idx);
    len      = nb * CPB;
    obs      = '0;
    exp      = '0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      obs[c] = ser[idx];
      exp[c] = fb[c / CPB];
      if (busy[idx] === 1'b1) busy_cnt++;
      if (done[idx] === 1'b1) done_cnt++;
      if (inject_at >= 0 && c == inject_at) begin
        start[idx] = 1'b1;
        data       = 8'hFF;
      end else if (inject_at >= 0 && c == inject_at + 1) begin
        start[idx] = 1'b0;
        data       = 8'($urandom);
      end
    end
    last_obs = obs;
    check_vec($sformatf("frame_bits dut%0d byte=%02h", idx, b), obs, exp);
    check($sformatf("busy_cycles dut%0d", idx), busy_cnt, len);
    check($sformatf("done_in_frame dut%0d", idx), done_cnt, 0);
    @(negedge clk);
    check($sformatf("busy_fall dut%0d", idx), int'(busy[idx]), 0);
    check($sformatf("done_pulse dut%0d", idx), int'(done[idx]), 1);
    check($sformatf("idle_line dut%0d", idx), int'(ser[idx]), 1);
  endtask

  task automatic idle_check(input int idx);
    @(negedge clk);
    check($sformatf("done_one_cycle dut%0d", idx), int'(done[idx]), 0);
    check($sformatf("stay_idle dut%0d", idx), int'(busy[idx]), 0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int idx;
    logic [7:0] b;

    rst_n = 1'b0;
    start = '0;
    data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_serial dut%0d", i), int'(ser[i]), 1);
      check($sformatf("reset_busy dut%0d", i), int'(busy[i]), 0);
      check($sformatf("reset_done dut%0d", i), int'(done[i]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, even parity, odd parity, 2 stop bits.
    send(0, 8'hA5); check_frame(0, 8'hA5, -1); idle_check(0);
    send(1, 8'hA5); check_frame(1, 8'hA5, -1);
    check("parity_even_A5", int'(last_obs[9*CPB+8]), 0);
    idle_check(1);
    send(2, 8'hA5); check_frame(2, 8'hA5, -1);
    check("parity_odd_A5", int'(last_obs[9*CPB+8]), 1);
    idle_check(2);
    send(1, 8'h07); check_frame(1, 8'h07, -1);
    check("parity_even_07", int'(last_obs[9*CPB+8]), 1);
    idle_check(1);
    send(3, 8'h00); check_frame(3, 8'h00, -1); idle_check(3);

    // Request while busy is dropped.
    send(0, 8'h3C); check_frame(0, 8'h3C, 50); idle_check(0);
    busy_cnt = 0;
    done_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy[0] !== 1'b0) busy_cnt++;
      if (done[0] !== 1'b0) done_cnt++;
    end
    check("no_extra_frame_busy", busy_cnt, 0);
    check("no_extra_frame_done", done_cnt, 0);

    // tx_start held high: second frame accepted in the tx_done cycle.
    @(negedge clk);
    data     = 8'h55;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    data = 8'h0F;
    check_frame(0, 8'h55, -1);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    data     = 8'($urandom);
    check_frame(0, 8'h0F, -1);
    idle_check(0);

    // Asynchronous reset during data bit 4.
    send(0, 8'hE0);
    repeat (86) @(negedge clk);
    check("pre_reset_line_low", int'(ser[0]), 0);
    check("pre_reset_busy", int'(busy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_line", int'(ser[0]), 1);
    check("async_reset_busy", int'(busy[0]), 0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0] !== 1'b0) done_cnt++;
    end
    check("reset_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h81); check_frame(0, 8'h81, -1); idle_check(0);

    // Random configurations and bytes.
    for (int n = 0; n < 16; n++) begin
      idx = int'($urandom_range(0, 3));
      b   = 8'($urandom);
      send(idx, b);
      check_frame(idx, b, -1);
      idle_check(idx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
